game_state_ctrl: RTL and testbench
==================================

// Module: game_state_ctrl
// PURPOSE
//  Game-flow FSM upstream of the VGA picture mux. Produces the 2-bit screen state
//  (0=START, 1=GAME, 2=END) that selects the start, game or end picture.
//  Latches key/hit events and commits state changes only on frame boundaries so
//  the screen never switches mid-frame. Also keeps the game countdown and pulses
//  game_init for the game-logic blocks.
// PARAMETERS
//  FPS       60  frame_tick pulses per second (2..255)
//  GAME_SEC  60  game duration in seconds (1..255)
//  END_SEC   5   end-screen hold time in seconds before auto-return to START (1..255)
// PORTS
//  sys_clk     in   1  system clock
//  sys_rst_n   in   1  asynchronous active-low reset
//  frame_tick  in   1  1-cycle pulse per frame (start of vertical blank)
//  key_start   in   1  debounced 1-cycle start/restart pulse
//  hit         in   1  1-cycle game-over event from game logic
//  key_pause   in   1  debounced 1-cycle pause toggle (used only with GAME_PAUSE_EN)
//  state       out  2  screen select: 0 START, 1 GAME, 2 END; 3 never driven
//  game_init   out  1  1-cycle pulse on every entry into GAME
//  time_left   out  8  remaining game seconds
//  paused      out  1  pause flag
// BEHAVIOUR
//  - Reset (async, any time incl. mid-game): state=0, game_init=0, time_left=GAME_SEC,
//    paused=0, frame/end counters=0, start_req=over_req=0.
//  - start_req: set by key_start while in START or END. over_req: set by hit while
//    in GAME and not paused. Events in other states are dropped. An event in the
//    same cycle as frame_tick counts for that tick. Both reqs clear on any transition.
//  - State updates only on a cycle with frame_tick=1. The new value is visible the
//    next cycle. game_init is high for exactly that one cycle.
//  - START: if start_req -> GAME, time_left<=GAME_SEC, frame cnt<=0.
//  - GAME: each unpaused tick increments frame cnt. At FPS-1 it wraps to 0 and
//    time_left decrements. Decrement to 0 -> END on that tick. over_req -> END with
//    time_left frozen. Timeout and over_req on the same tick -> END (time_left=0).
//  - END: each tick increments end cnt. If start_req -> GAME (restart) with game_init,
//    time_left reload, end cnt<=0. Else end cnt reaching END_SEC*FPS-1 -> START,
//    time_left<=GAME_SEC. start_req has priority over timeout on the same tick.
//  - END_SEC*FPS is held in a 16-bit counter. time_left never underflows.
//  - Illegal state 3 -> START on the next clock, with counters and reqs cleared.
//  - Outputs are registered. No combinational path from inputs to outputs.
// CONFIGURATION
//  GAME_PAUSE_EN defined:
//   - key_pause in GAME toggles paused immediately (next cycle, not frame-aligned).
//   - While paused, frame cnt and time_left hold and hit is ignored.
//   - paused clears on leaving GAME and on reset.
//  GAME_PAUSE_EN undefined:
//   - key_pause is ignored and paused is tied to 0.
// TESTING (FPS=4, GAME_SEC=3, END_SEC=2 unless noted)
//  1 reset; key_start, frame_tick 5 cycles later -> state 0->1 the cycle after the
//    tick, game_init high 1 cycle, time_left=3
//  2 in GAME, 4 ticks -> time_left=2; 12 ticks total -> state=2, time_left=0
//  3 hit between ticks at time_left=2 -> state stays 1 until next tick, then 2;
//    time_left holds 2
//  4 END, no key, 8 ticks -> state=0, time_left=3; separately key_start in END + tick
//    -> state=1, game_init pulse
//  5 sys_rst_n low mid-GAME (no clock edge) -> state=0, game_init=0, time_left=3
//    immediately
//  6 GAME_PAUSE_EN: key_pause -> paused=1; 10 ticks + hit -> time_left and state
//    unchanged; key_pause -> paused=0, countdown resumes

Source files
------------

// File: rtl/game_state_ctrl.sv
// Game-flow controller feeding the VGA picture mux.
// Screen state: 0 = START, 1 = GAME, 2 = END. All state changes are committed
// on frame_tick so the picture never switches mid-frame. Also keeps the game
// countdown in seconds and pulses game_init on every entry into GAME.
// Optional feature: define GAME_PAUSE_EN to enable the key_pause toggle.
// Without it, key_pause is ignored and paused is tied to 0.
module game_state_ctrl #(
  parameter int FPS      = 60,  // frame_tick pulses per second (2..255)
  parameter int GAME_SEC = 60,  // game duration in seconds (1..255)
  parameter int END_SEC  = 5    // end-screen hold in seconds (1..255)
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       frame_tick,
  input  logic       key_start,
  input  logic       hit,
  input  logic       key_pause,
  output logic [1:0] state,
  output logic       game_init,
  output logic [7:0] time_left,
  output logic       paused
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_GAME  = 2'd1,
    ST_END   = 2'd2
  } state_e;

  localparam logic [7:0]  GAME_SEC_L = 8'(GAME_SEC);
  localparam logic [7:0]  FRAME_LAST = 8'(FPS - 1);
  // The end-screen hold spans END_SEC*FPS frames, which needs up to 16 bits.
  localparam logic [15:0] END_LAST   = 16'(END_SEC * FPS - 1);

  state_e      state_q, state_d;
  logic        game_init_q, game_init_d;
  logic [7:0]  time_left_q, time_left_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [15:0] end_cnt_q, end_cnt_d;
  logic        start_req_q, start_req_d;
  logic        over_req_q, over_req_d;
  logic        paused_q, paused_d;
  logic        frame_wrap;

`ifndef GAME_PAUSE_EN
  // key_pause has no function in this build.
  logic unused_key_pause;
  assign unused_key_pause = key_pause;
`endif

  // State and counter registers, all cleared asynchronously.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create ordering-dependent races.
    if (!sys_rst_n) begin
      state_q     <= ST_START;
      game_init_q <= 1'b0;
      time_left_q <= GAME_SEC_L;
      frame_cnt_q <= '0;
      end_cnt_q   <= '0;
      start_req_q <= 1'b0;
      over_req_q  <= 1'b0;
      paused_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      game_init_q <= game_init_d;
      time_left_q <= time_left_d;
      frame_cnt_q <= frame_cnt_d;
      end_cnt_q   <= end_cnt_d;
      start_req_q <= start_req_d;
      over_req_q  <= over_req_d;
      paused_q    <= paused_d;
    end
  end

  // Event latching, frame-aligned transitions and countdown bookkeeping.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d     = state_q;
    game_init_d = 1'b0;
    time_left_d = time_left_q;
    frame_cnt_d = frame_cnt_q;
    end_cnt_d   = end_cnt_q;
    frame_wrap  = (frame_cnt_q == FRAME_LAST);

    // An event arriving on the tick cycle itself counts for that tick.
    start_req_d = start_req_q | (key_start & ((state_q == ST_START) | (state_q == ST_END)));
    over_req_d  = over_req_q | (hit & (state_q == ST_GAME) & ~paused_q);

`ifdef GAME_PAUSE_EN
    // Pause toggles immediately, not frame-aligned.
    paused_d = paused_q ^ (key_pause & (state_q == ST_GAME));
`else
    paused_d = 1'b0;
`endif

    case (state_q)
      ST_START: begin
        if (frame_tick && start_req_d) begin
          state_d     = ST_GAME;
          game_init_d = 1'b1;
          time_left_d = GAME_SEC_L;
          frame_cnt_d = '0;
          start_req_d = 1'b0;
          over_req_d  = 1'b0;
        end
      end

      ST_GAME: begin
        // A paused game ignores ticks entirely: no counting, no transition.
        if (frame_tick && !paused_q) begin
          frame_cnt_d = frame_wrap ? '0 : frame_cnt_q + 8'd1;
          if (frame_wrap && (time_left_q <= 8'd1)) begin
            // Timeout wins the countdown race even if a hit arrived too.
            state_d     = ST_END;
            time_left_d = '0;
            end_cnt_d   = '0;
            start_req_d = 1'b0;
            over_req_d  = 1'b0;
            paused_d    = 1'b0;
          end else if (over_req_d) begin
            // Game over: time_left freezes at its current value.
            state_d     = ST_END;
            end_cnt_d   = '0;
            start_req_d = 1'b0;
            over_req_d  = 1'b0;
            paused_d    = 1'b0;
          end else if (frame_wrap) begin
            time_left_d = time_left_q - 8'd1;
          end
        end
      end

      ST_END: begin
        if (frame_tick) begin
          if (start_req_d) begin
            state_d     = ST_GAME;
            game_init_d = 1'b1;
            time_left_d = GAME_SEC_L;
            frame_cnt_d = '0;
            end_cnt_d   = '0;
            start_req_d = 1'b0;
            over_req_d  = 1'b0;
          end else if (end_cnt_q == END_LAST) begin
            state_d     = ST_START;
            time_left_d = GAME_SEC_L;
            end_cnt_d   = '0;
            start_req_d = 1'b0;
            over_req_d  = 1'b0;
          end else begin
            end_cnt_d = end_cnt_q + 16'd1;
          end
        end
      end

      default: begin
        // Unreachable encoding: recover to a clean START.
        state_d     = ST_START;
        time_left_d = GAME_SEC_L;
        frame_cnt_d = '0;
        end_cnt_d   = '0;
        start_req_d = 1'b0;
        over_req_d  = 1'b0;
        paused_d    = 1'b0;
      end
    endcase
  end

  assign state     = state_q;
  assign game_init = game_init_q;
  assign time_left = time_left_q;
  assign paused    = paused_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl (FPS=4, GAME_SEC=3, END_SEC=2).
// Directed scenarios followed by randomized stimulus, all compared each cycle
// against a frame-counting reference model. Pause scenarios need GAME_PAUSE_EN.
module tb_game_state_ctrl;

  localparam int FPS      = 4;
  localparam int GAME_SEC = 3;
  localparam int END_SEC  = 2;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       frame_tick;
  logic       key_start;
  logic       hit;
  logic       key_pause;
  logic [1:0] state;
  logic       game_init;
  logic [7:0] time_left;
  logic       paused;

  int n_checks = 0;
  int n_pass   = 0;

  game_state_ctrl #(.FPS(FPS), .GAME_SEC(GAME_SEC), .END_SEC(END_SEC)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .frame_tick (frame_tick),
    .key_start  (key_start),
    .hit        (hit),
    .key_pause  (key_pause),
    .state      (state),
    .game_init  (game_init),
    .time_left  (time_left),
    .paused     (paused)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Reference model: screen plus elapsed game frames and elapsed end frames.
  int m_screen;       // 0 START, 1 GAME, 2 END
  int m_game_frames;  // frames played in the current game
  int m_end_frames;   // frames spent on the end screen
  bit m_init;
  bit m_paused;
  bit m_want_start;
  bit m_want_over;

  function automatic int m_time_left();
    return GAME_SEC - (m_game_frames / FPS);
  endfunction

  task automatic model_reset();
    m_screen      = 0;
    m_game_frames = 0;
    m_end_frames  = 0;
    m_init        = 1'b0;
    m_paused      = 1'b0;
    m_want_start  = 1'b0;
    m_want_over   = 1'b0;
  endtask

  task automatic model_step(input bit t, input bit ks, input bit h, input bit kp);
    bit pause_next;
    m_init = 1'b0;
    if (ks && m_screen != 1) m_want_start = 1'b1;
    if (h && m_screen == 1 && !m_paused) m_want_over = 1'b1;
    pause_next = m_paused;
`ifdef GAME_PAUSE_EN
    if (kp && m_screen == 1) pause_next = !m_paused;
`else
    if (kp) pause_next = 1'b0;
`endif
    if (t) begin
      case (m_screen)
        0: if (m_want_start) begin
          m_screen = 1; m_init = 1'b1; m_game_frames = 0;
          m_want_start = 1'b0; m_want_over = 1'b0;
        end
        1: if (!m_paused) begin
          if (m_game_frames + 1 == GAME_SEC * FPS) begin
            m_game_frames++;
            m_screen = 2; m_end_frames = 0; pause_next = 1'b0;
            m_want_start = 1'b0; m_want_over = 1'b0;
          end else if (m_want_over) begin
            m_screen = 2; m_end_frames = 0; pause_next = 1'b0;
            m_want_start = 1'b0; m_want_over = 1'b0;
          end else begin
            m_game_frames++;
          end
        end
        default: begin
          if (m_want_start) begin
            m_screen = 1; m_init = 1'b1; m_game_frames = 0;
            m_want_start = 1'b0; m_want_over = 1'b0;
          end else if (m_end_frames + 1 == END_SEC * FPS) begin
            m_screen = 0; m_game_frames = 0;
            m_want_start = 1'b0; m_want_over = 1'b0;
          end else begin
            m_end_frames++;
          end
        end
      endcase
    end
    m_paused = pause_next;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"},     32'(state),     32'(m_screen));
    check({tag, ".game_init"}, 32'(game_init), 32'(m_init));
    check({tag, ".time_left"}, 32'(time_left), 32'(m_time_left()));
    check({tag, ".paused"},    32'(paused),    32'(m_paused));
  endtask

  // One clock: drive inputs, let the edge happen, step the model, compare.
  task automatic cycle(input string tag, input bit t, input bit ks, input bit h, input bit kp);
    frame_tick = t; key_start = ks; hit = h; key_pause = kp;
    @(posedge sys_clk);
    model_step(t, ks, h, kp);
    #1;
    frame_tick = 1'b0; key_start = 1'b0; hit = 1'b0; key_pause = 1'b0;
    check_all(tag);
  endtask

  // n frame ticks, each followed by a couple of idle cycles.
  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      cycle(tag, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Asynchronous reset asserted between clock edges, checked before any edge.
  task automatic async_reset(input string tag);
    #2 sys_rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, ".rst_state"},     32'(state),     32'd0);
    check({tag, ".rst_game_init"}, 32'(game_init), 32'd0);
    check({tag, ".rst_time_left"}, 32'(time_left), 32'(GAME_SEC));
    check({tag, ".rst_paused"},    32'(paused),    32'd0);
    #3 sys_rst_n = 1'b1;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    frame_tick = 1'b0; key_start = 1'b0; hit = 1'b0; key_pause = 1'b0;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    check_all("reset");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // 1: start press, tick five cycles later, GAME entry with one-cycle init.
    cycle("t1", 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) cycle("t1", 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("t1", 1'b1, 1'b0, 1'b0, 1'b0);
    check("t1.state_game", 32'(state), 32'd1);
    check("t1.init_pulse", 32'(game_init), 32'd1);
    check("t1.time_left", 32'(time_left), 32'd3);
    cycle("t1", 1'b0, 1'b0, 1'b0, 1'b0);
    check("t1.init_drop", 32'(game_init), 32'd0);

    // 2: one second of ticks, then the full timeout.
    ticks("t2", 4);
    check("t2.one_sec", 32'(time_left), 32'd2);
    ticks("t2", 8);
    check("t2.end_state", 32'(state), 32'd2);
    check("t2.end_time", 32'(time_left), 32'd0);

    // 4: END hold runs out back to START with reload.
    ticks("t4", 8);
    check("t4.auto_start", 32'(state), 32'd0);
    check("t4.reload", 32'(time_left), 32'd3);

    // 3: hit mid-frame commits only on the next tick, time_left frozen.
    cycle("t3", 1'b1, 1'b1, 1'b0, 1'b0);
    ticks("t3", 4);
    cycle("t3", 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("t3", 1'b0, 1'b0, 1'b0, 1'b0);
    check("t3.wait_tick", 32'(state), 32'd1);
    cycle("t3", 1'b1, 1'b0, 1'b0, 1'b0);
    check("t3.over", 32'(state), 32'd2);
    check("t3.frozen", 32'(time_left), 32'd2);

    // 4b: restart from END with game_init.
    cycle("t4b", 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("t4b", 1'b1, 1'b0, 1'b0, 1'b0);
    check("t4b.restart", 32'(state), 32'd1);
    check("t4b.init", 32'(game_init), 32'd1);

    // 5: asynchronous reset in the middle of a game.
    ticks("t5", 5);
    async_reset("t5");

`ifdef GAME_PAUSE_EN
    // 6: pause freezes countdown and ignores hit; unpause resumes.
    cycle("t6", 1'b1, 1'b1, 1'b0, 1'b0);
    cycle("t6", 1'b0, 1'b0, 1'b0, 1'b1);
    check("t6.paused", 32'(paused), 32'd1);
    ticks("t6", 10);
    cycle("t6", 1'b0, 1'b0, 1'b1, 1'b0);
    ticks("t6", 1);
    check("t6.hold_state", 32'(state), 32'd1);
    check("t6.hold_time", 32'(time_left), 32'd3);
    cycle("t6", 1'b0, 1'b0, 1'b0, 1'b1);
    check("t6.unpaused", 32'(paused), 32'd0);
    ticks("t6", 4);
    check("t6.resumed", 32'(time_left), 32'd2);
`endif

    // Randomized traffic with occasional mid-run resets.
    for (int i = 0; i < 4000; i++) begin
      cycle("rand",
            ($urandom_range(2) == 0),
            ($urandom_range(11) == 0),
            ($urandom_range(13) == 0),
            ($urandom_range(17) == 0));
      if ($urandom_range(700) == 0) async_reset("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
